aes_inv_cipher: RTL
===================

Name: aes_inv_cipher

Overview:
- Iterative AES-128 decryptor. It is the receive-side counterpart of the AES-128 encrypt datapath and shares its byte ordering and round primitives.
- Accepts a 128-bit ciphertext and cipher key, and returns plaintext after a fixed latency. Processes one round per clock.
- Derives the decryption round keys on the fly. It first expands the key forward to round 10, then steps the key schedule backward, one key per round.

Parameters:
- NR, 10: round count. Only 10 (AES-128) is supported; any other value is an elaboration error.
- KEY_REUSE, 1: when 1, a retained round-10 key can be reused through reuse_key. When 0, reuse_key is ignored and forward expansion always runs.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request, sampled only while busy=0
- reuse_key  input  1  qualifies start: skip forward expansion and use the retained round-10 key
- key  input  128  cipher key, byte0 = [127:120], column-major per FIPS-197
- cipher_text  input  128  ciphertext, same byte order as key
- plain_text  output  128  result; holds its value until the next completed operation
- valid  output  1  one-cycle pulse when plain_text updates
- busy  output  1  high from the cycle after start is accepted until the FINAL edge

Behaviour:
- Reset (rstn=0, asynchronous): FSM=IDLE; plain_text=0, valid=0, busy=0; state, round keys and round counter cleared; key_ok flag=0.
- Reset mid-operation aborts immediately. No valid is produced and the retained key becomes invalid.
- FSM states: IDLE, KEYEXP, INIT, ROUND, FINAL.
- IDLE, start=1:
  - latch cipher_text.
  - If reuse_key & KEY_REUSE & key_ok: go to INIT; the key input is ignored.
  - Otherwise: latch key into rk, set rnd=1, go to KEYEXP.
- KEYEXP, 10 cycles:
  - rk <= forward_expand(rk, Rcon[rnd]); rnd increments.
  - After the rnd=10 step, store rk as rk10, set key_ok=1, go to INIT.
- INIT, 1 cycle: state <= ct ^ rk10; rk <= rk10; rnd <= 10.
- ROUND, 9 cycles, rnd 10 down to 2:
  - rk_prev = inverse_expand(rk, Rcon[rnd]).
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev); rk <= rk_prev; rnd decrements.
- FINAL, 1 cycle:
  - rk0 = inverse_expand(rk, Rcon[1]).
  - plain_text <= InvSubBytes(InvShiftRows(state)) ^ rk0; valid <= 1; go to IDLE.
- inverse_expand on words w0..w3, where w0 = [127:96]:
  - w3' = w3^w2; w2' = w2^w1; w1' = w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon,24'h0}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, supplied from a constant table. No runtime xtime inversion.
- Latency, start accepted at edge N:
  - Full expansion: valid is high in the cycle after edge N+21.
  - Reuse: valid is high in the cycle after edge N+11.
- valid is high for exactly one cycle. busy deasserts on the same edge that raises valid.
- start while busy=1 is ignored and not queued.
- start in the cycle valid is high is accepted (back-to-back), giving a throughput of one block per 22 or 12 cycles.
- reuse_key with key_ok=0 falls back to full expansion.
- Width rules: all GF(2^8) arithmetic is XOR and xtime mod 0x11b. There are no carries.

Decomposition:
- Shared package/include aes_pkg:
  - forward and inverse S-box tables
  - Rcon table
  - xtime / gf_mul functions
  - state byte-index helpers
  - state encodings for the FSM
- Combinational round sub-module inv_round holds InvShiftRows, InvSubBytes and InvMixColumns, with a bypass_mix input for the final round.
- The key schedule step uses the existing forward S-box SubWord inside the top-level module.

Test Plan:
- FIPS-197 C.1:
  - key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff.
  - valid arrives at start+22 cycles.
  - rk10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B:
  - key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key reuse: after B, start with reuse_key=1, the same ct and key=0 -> the same pt with 12-cycle latency. Then reuse_key=1 after reset -> full 22-cycle path, correct pt.
- Back-to-back and busy: start held high continuously -> the second operation begins in the valid cycle and mid-run starts are ignored. Expect exactly one valid per operation with correct pts.
- Reset at cycle 7 of ROUND -> outputs 0 and no valid. A following start completes correctly from IDLE.
- Random vectors: 1000 key/pt pairs encrypted by the reference model -> every decrypted pt matches and plain_text is stable between valid pulses.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES primitives for the AES-128 datapaths.
//   - FSM state encoding for the iterative cipher controllers
//   - forward / inverse S-box tables, Rcon table
//   - GF(2^8) xtime / gf_mul (XOR arithmetic, reduction by 0x11b)
//   - state byte-index helpers: byte i of a 128-bit block sits at [127-8*i -: 8],
//     and byte (row r, column c) is byte 4*c + r (column-major)
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_INIT,
        ST_ROUND,
        ST_FINAL
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    // Indexed by round number 1..10; the unused slots keep a 4-bit index in range.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
        return col * 4 + row;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned idx);
        return s[127 - 8 * idx -: 8];
    endfunction

endpackage

// File: rtl/inv_round.sv
// inv_round: combinational AES inverse round.
//   state_out = InvMixColumns(InvSubBytes(InvShiftRows(state_in)) ^ round_key)
//   with bypass_mix=1 the InvMixColumns stage is skipped (last round).
// Ports:
//   state_in   [127:0]  round input block
//   round_key  [127:0]  round key added after InvSubBytes
//   bypass_mix          skip InvMixColumns
//   state_out  [127:0]  round output block
module inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         bypass_mix,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;
    logic [7:0]   a0, a1, a2, a3;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        keyed   = '0;
        mixed   = '0;
        a0      = '0;
        a1      = '0;
        a2      = '0;
        a3      = '0;

        // Row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8 * byte_idx(r, c) -: 8] = get_byte(state_in, byte_idx(r, (c + 4 - r) % 4));
            end
        end

        for (int i = 0; i < 16; i++) begin
            subbed[127 - 8 * i -: 8] = INV_SBOX[get_byte(shifted, i)];
        end

        keyed = subbed ^ round_key;

        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(keyed, byte_idx(0, c));
            a1 = get_byte(keyed, byte_idx(1, c));
            a2 = get_byte(keyed, byte_idx(2, c));
            a3 = get_byte(keyed, byte_idx(3, c));
            mixed[127 - 8 * byte_idx(0, c) -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            mixed[127 - 8 * byte_idx(1, c) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            mixed[127 - 8 * byte_idx(2, c) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            mixed[127 - 8 * byte_idx(3, c) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end

        state_out = bypass_mix ? keyed : mixed;
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryptor, one round per clock.
// Round keys are derived on the fly: forward expansion to round 10, then the
// schedule is stepped backward one key per round. The round-10 key is retained
// so a following block under the same key can skip the forward expansion.
// Ports:
//   clk                 rising-edge clock
//   rstn                asynchronous active-low reset
//   start               one-cycle request, sampled only while busy=0
//   reuse_key           with start: use the retained round-10 key
//   key         [127:0] cipher key, byte0 = [127:120]
//   cipher_text [127:0] ciphertext
//   plain_text  [127:0] result, held until the next completed operation
//   valid               one-cycle pulse when plain_text updates
//   busy                operation in progress
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_KEYEXP  | forward key expansion, rnd 1..10 (10 cycles)
// ST_INIT    | state = ct ^ rk10, reload rk from rk10
// ST_ROUND   | inverse rounds with MixColumns, rnd 10..2 (9 cycles)
// ST_FINAL   | last inverse round without MixColumns, write plain_text
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         reuse_key,
    input  logic [127:0] key,
    input  logic [127:0] cipher_text,
    output logic [127:0] plain_text,
    output logic         valid,
    output logic         busy
);

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher supports only NR = 10");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: recover the three trailing words first, then w0
    // needs the previous w3 for its SubWord term.
    function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    aes_state_e   fsm, fsm_nx;
    logic [127:0] ct_q, ct_nx;
    logic [127:0] st_q, st_nx;
    logic [127:0] rk_q, rk_nx;
    logic [127:0] rk10, rk10_nx;
    logic [3:0]   rnd, rnd_nx;
    logic         key_ok, key_ok_nx;
    logic [127:0] pt_nx;
    logic         valid_nx;

    logic [127:0] rk_fwd;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

    assign rk_fwd  = fwd_expand(rk_q, RCON[rnd]);
    assign rk_prev = inv_expand(rk_q, RCON[rnd]);

    inv_round u_inv_round (
        .state_in   (st_q),
        .round_key  (rk_prev),
        .bypass_mix (fsm == ST_FINAL),
        .state_out  (round_out)
    );

    assign busy = (fsm != ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm        <= ST_IDLE;
            ct_q       <= '0;
            st_q       <= '0;
            rk_q       <= '0;
            rk10       <= '0;
            rnd        <= '0;
            key_ok     <= 1'b0;
            plain_text <= '0;
            valid      <= 1'b0;
        end else begin
            fsm        <= fsm_nx;
            ct_q       <= ct_nx;
            st_q       <= st_nx;
            rk_q       <= rk_nx;
            rk10       <= rk10_nx;
            rnd        <= rnd_nx;
            key_ok     <= key_ok_nx;
            plain_text <= pt_nx;
            valid      <= valid_nx;
        end
    end

    always_comb begin
        fsm_nx    = fsm;
        ct_nx     = ct_q;
        st_nx     = st_q;
        rk_nx     = rk_q;
        rk10_nx   = rk10;
        rnd_nx    = rnd;
        key_ok_nx = key_ok;
        pt_nx     = plain_text;
        valid_nx  = 1'b0;

        case (fsm)
            ST_IDLE: begin
                if (start) begin
                    ct_nx = cipher_text;
                    if (KEY_REUSE && reuse_key && key_ok) begin
                        fsm_nx = ST_INIT;
                    end else begin
                        rk_nx  = key;
                        rnd_nx = 4'd1;
                        fsm_nx = ST_KEYEXP;
                    end
                end
            end
            ST_KEYEXP: begin
                rk_nx  = rk_fwd;
                rnd_nx = rnd + 4'd1;
                if (rnd == LAST_RND) begin
                    rk10_nx   = rk_fwd;
                    key_ok_nx = 1'b1;
                    fsm_nx    = ST_INIT;
                end
            end
            ST_INIT: begin
                st_nx  = ct_q ^ rk10;
                rk_nx  = rk10;
                rnd_nx = LAST_RND;
                fsm_nx = ST_ROUND;
            end
            ST_ROUND: begin
                st_nx  = round_out;
                rk_nx  = rk_prev;
                rnd_nx = rnd - 4'd1;
                if (rnd == 4'd2) fsm_nx = ST_FINAL;
            end
            ST_FINAL: begin
                pt_nx    = round_out;
                valid_nx = 1'b1;
                fsm_nx   = ST_IDLE;
            end
            default: fsm_nx = ST_IDLE;
        endcase
    end

endmodule
